// File: rtl/p4_router_tap_stats.sv
// Passive per-tap AXIS statistics: packet/byte/oversize counts and max packet length,
// with atomic snapshot into shadow registers and a registered readout port.
module p4_router_tap_stats #(
    parameter int unsigned NUM_TAPS      = 3,
    parameter int unsigned DATA_BYTES    = 64,
    parameter int unsigned CNT_WIDTH     = 64,
    parameter int unsigned MTU_BYTES     = 2000,
    parameter bit          SATURATE      = 1'b1,
    parameter bit          CLEAR_ON_SNAP = 1'b0
) (
    input  logic                             clk,
    input  logic                             sreset,
    input  logic [NUM_TAPS-1:0]              tap_tvalid,
    input  logic [NUM_TAPS-1:0]              tap_tready,
    input  logic [NUM_TAPS-1:0]              tap_tlast,
    input  logic [NUM_TAPS*DATA_BYTES-1:0]   tap_tkeep,
    input  logic                             clear,
    input  logic                             snap_req,
    output logic                             snap_done,
    input  logic                             rd_en,
    input  logic [$clog2(NUM_TAPS)+2-1:0]    rd_addr,
    output logic [CNT_WIDTH-1:0]             rd_data,
    output logic                             rd_valid
);

    localparam int unsigned BW = $clog2(DATA_BYTES + 1);
    localparam int unsigned AW = $clog2(NUM_TAPS) + 2;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic logic [BW-1:0] f_popcount(input logic [DATA_BYTES-1:0] keep);
        logic [BW-1:0] n;
        n = '0;
        for (int unsigned b = 0; b < DATA_BYTES; b++) begin
            n = n + BW'(keep[b]);
        end
        return n;
    endfunction

    function automatic logic [15:0] f_len(input logic [15:0] acc, input logic [BW-1:0] n);
        logic [16:0] s;
        s = {1'b0, acc} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic cnt_t f_add(input cnt_t a, input cnt_t inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, inc};
        if (SATURATE && s[CNT_WIDTH]) begin
            return '1;
        end
        return s[CNT_WIDTH-1:0];
    endfunction

    logic [15:0]         r_len_acc [NUM_TAPS];
    cnt_t                r_pkts    [NUM_TAPS];
    cnt_t                r_bytes   [NUM_TAPS];
    cnt_t                r_ovs     [NUM_TAPS];
    cnt_t                r_max     [NUM_TAPS];
    cnt_t                r_shadow  [NUM_TAPS][4];

    logic [BW-1:0]       w_beat_bytes [NUM_TAPS];
    logic [15:0]         w_len        [NUM_TAPS];
    logic [15:0]         w_acc_nxt    [NUM_TAPS];
    cnt_t                w_pkts_nxt   [NUM_TAPS];
    cnt_t                w_bytes_nxt  [NUM_TAPS];
    cnt_t                w_ovs_nxt    [NUM_TAPS];
    cnt_t                w_max_nxt    [NUM_TAPS];
    logic [NUM_TAPS-1:0] w_beat;
    logic [NUM_TAPS-1:0] w_eop;
    logic                w_snap_clr;
    logic [AW-1:0]       w_rd_tap;
    cnt_t                w_rd_val;

    assign w_snap_clr = snap_req && CLEAR_ON_SNAP;
    assign w_rd_tap   = rd_addr >> 2;

    // Clear-on-snap restarts the live counters from zero but still adds this cycle's event.
    always_comb begin
        for (int unsigned t = 0; t < NUM_TAPS; t++) begin
            w_beat[t]       = tap_tvalid[t] & tap_tready[t];
            w_eop[t]        = w_beat[t] & tap_tlast[t];
            w_beat_bytes[t] = f_popcount(tap_tkeep[t*DATA_BYTES +: DATA_BYTES]);
            w_len[t]        = f_len(r_len_acc[t], w_beat_bytes[t]);
            w_acc_nxt[t]    = w_beat[t] ? (tap_tlast[t] ? 16'd0 : w_len[t]) : r_len_acc[t];

            w_pkts_nxt[t]  = w_snap_clr ? '0 : r_pkts[t];
            w_bytes_nxt[t] = w_snap_clr ? '0 : r_bytes[t];
            w_ovs_nxt[t]   = w_snap_clr ? '0 : r_ovs[t];
            w_max_nxt[t]   = w_snap_clr ? '0 : r_max[t];

            if (w_beat[t]) begin
                w_bytes_nxt[t] = f_add(w_bytes_nxt[t], CNT_WIDTH'(w_beat_bytes[t]));
            end
            if (w_eop[t]) begin
                w_pkts_nxt[t] = f_add(w_pkts_nxt[t], cnt_t'(1));
                if (32'(w_len[t]) > MTU_BYTES) begin
                    w_ovs_nxt[t] = f_add(w_ovs_nxt[t], cnt_t'(1));
                end
                if (CNT_WIDTH'(w_len[t]) > w_max_nxt[t]) begin
                    w_max_nxt[t] = CNT_WIDTH'(w_len[t]);
                end
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        for (int unsigned t = 0; t < NUM_TAPS; t++) begin
            if (w_rd_tap == AW'(t)) begin
                w_rd_val = r_shadow[t][rd_addr[1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            snap_done <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            for (int unsigned t = 0; t < NUM_TAPS; t++) begin
                r_len_acc[t] <= '0;
                r_pkts[t]    <= '0;
                r_bytes[t]   <= '0;
                r_ovs[t]     <= '0;
                r_max[t]     <= '0;
                for (int unsigned s = 0; s < 4; s++) begin
                    r_shadow[t][s] <= '0;
                end
            end
        end else begin
            snap_done <= snap_req;
            rd_valid  <= rd_en;
            if (rd_en) begin
                rd_data <= w_rd_val;
            end
            for (int unsigned t = 0; t < NUM_TAPS; t++) begin
                if (snap_req) begin
                    r_shadow[t][0] <= r_pkts[t];
                    r_shadow[t][1] <= r_bytes[t];
                    r_shadow[t][2] <= r_ovs[t];
                    r_shadow[t][3] <= r_max[t];
                end
                if (clear) begin
                    r_len_acc[t] <= '0;
                    r_pkts[t]    <= '0;
                    r_bytes[t]   <= '0;
                    r_ovs[t]     <= '0;
                    r_max[t]     <= '0;
                end else begin
                    r_len_acc[t] <= w_acc_nxt[t];
                    r_pkts[t]    <= w_pkts_nxt[t];
                    r_bytes[t]   <= w_bytes_nxt[t];
                    r_ovs[t]     <= w_ovs_nxt[t];
                    r_max[t]     <= w_max_nxt[t];
                end
            end
        end
    end

endmodule

// File: tb/tb_p4_router_tap_stats.sv
// Scoreboard bench: two 16-bit-counter instances (saturating / wrapping with clear-on-snap)
// driven by shared directed and random stimulus, checked against a per-cycle reference model.
module tb_p4_router_tap_stats;

    localparam int NT  = 3;
    localparam int DB  = 64;
    localparam int CW  = 16;
    localparam int AW  = 4;
    localparam int MTU = 2000;

    logic             clk = 1'b0;
    logic             sreset = 1'b1;
    logic [NT-1:0]    tap_tvalid = '0;
    logic [NT-1:0]    tap_tready = '1;
    logic [NT-1:0]    tap_tlast = '0;
    logic [NT*DB-1:0] tap_tkeep = '0;
    logic             clear = 1'b0;
    logic             snap_req = 1'b0;
    logic             rd_en = 1'b0;
    logic [AW-1:0]    rd_addr = '0;

    logic             snap_done_a, snap_done_b;
    logic             rd_valid_a, rd_valid_b;
    logic [CW-1:0]    rd_data_a, rd_data_b;

    always #5 clk = ~clk;

    p4_router_tap_stats #(
        .NUM_TAPS(NT), .DATA_BYTES(DB), .CNT_WIDTH(CW), .MTU_BYTES(MTU),
        .SATURATE(1'b1), .CLEAR_ON_SNAP(1'b0)
    ) u_sat (
        .clk(clk), .sreset(sreset), .tap_tvalid(tap_tvalid), .tap_tready(tap_tready),
        .tap_tlast(tap_tlast), .tap_tkeep(tap_tkeep), .clear(clear), .snap_req(snap_req),
        .snap_done(snap_done_a), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a)
    );

    p4_router_tap_stats #(
        .NUM_TAPS(NT), .DATA_BYTES(DB), .CNT_WIDTH(CW), .MTU_BYTES(MTU),
        .SATURATE(1'b0), .CLEAR_ON_SNAP(1'b1)
    ) u_wrap (
        .clk(clk), .sreset(sreset), .tap_tvalid(tap_tvalid), .tap_tready(tap_tready),
        .tap_tlast(tap_tlast), .tap_tkeep(tap_tkeep), .clear(clear), .snap_req(snap_req),
        .snap_done(snap_done_b), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b)
    );

    typedef struct {
        int              cyc;
        longint unsigned val;
    } rd_exp_t;

    rd_exp_t         qa[$];
    rd_exp_t         qb[$];
    int              snap_q[$];
    int              cyc = 0;
    int              npass = 0;
    int              ntotal = 0;

    // Reference state: [config][tap][sel], sel 0 packets, 1 bytes, 2 oversize, 3 max length.
    bit              cfg_sat [2] = '{1'b1, 1'b0};
    bit              cfg_cos [2] = '{1'b0, 1'b1};
    longint unsigned m_live [2][NT][4];
    longint unsigned m_shad [2][NT][4];
    longint unsigned m_acc  [NT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic longint unsigned madd(input int c, input longint unsigned a,
                                             input longint unsigned inc);
        longint unsigned s;
        s = a + inc;
        if (s <= 65535) return s;
        return cfg_sat[c] ? 65535 : (s % 65536);
    endfunction

    task automatic model_step();
        longint unsigned len, b;
        bit              beat, eop;
        int              t, s;
        if (sreset) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NT; i++)
                    for (int k = 0; k < 4; k++) begin
                        m_live[c][i][k] = 0;
                        m_shad[c][i][k] = 0;
                    end
            for (int i = 0; i < NT; i++) m_acc[i] = 0;
            return;
        end
        if (snap_req) snap_q.push_back(cyc + 1);
        if (rd_en) begin
            t = int'(rd_addr) / 4;
            s = int'(rd_addr) % 4;
            qa.push_back('{cyc + 1, (t < NT) ? m_shad[0][t][s] : 0});
            qb.push_back('{cyc + 1, (t < NT) ? m_shad[1][t][s] : 0});
        end
        if (snap_req)
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < NT; i++)
                    for (int k = 0; k < 4; k++) m_shad[c][i][k] = m_live[c][i][k];
        for (int i = 0; i < NT; i++) begin
            beat = tap_tvalid[i] && tap_tready[i];
            eop  = beat && tap_tlast[i];
            b    = $countones(tap_tkeep[i*DB +: DB]);
            len  = (m_acc[i] + b > 65535) ? 65535 : m_acc[i] + b;
            for (int c = 0; c < 2; c++) begin
                if (clear || (snap_req && cfg_cos[c]))
                    for (int k = 0; k < 4; k++) m_live[c][i][k] = 0;
                if (!clear) begin
                    if (beat) m_live[c][i][1] = madd(c, m_live[c][i][1], b);
                    if (eop) begin
                        m_live[c][i][0] = madd(c, m_live[c][i][0], 1);
                        if (len > MTU) m_live[c][i][2] = madd(c, m_live[c][i][2], 1);
                        if (len > m_live[c][i][3]) m_live[c][i][3] = len;
                    end
                end
            end
            if (clear) m_acc[i] = 0;
            else if (beat) m_acc[i] = tap_tlast[i] ? 0 : len;
        end
    endtask

    // Monitor: pops expectations whenever either DUT presents an output.
    always @(negedge clk) begin
        bit      exp_s;
        rd_exp_t e;
        exp_s = (snap_q.size() > 0) && (snap_q[0] == cyc);
        if (exp_s) void'(snap_q.pop_front());
        if (snap_done_a === 1'b1 || exp_s) check("snap_done_a", snap_done_a, exp_s);
        if (snap_done_b === 1'b1 || exp_s) check("snap_done_b", snap_done_b, exp_s);
        if (rd_valid_a === 1'b1) begin
            if (qa.size() == 0) check("rd_valid_a_unexpected", 1, 0);
            else begin
                e = qa.pop_front();
                check("rd_latency_a", cyc, e.cyc);
                check("rd_data_a", rd_data_a, e.val);
            end
        end
        if (rd_valid_b === 1'b1) begin
            if (qb.size() == 0) check("rd_valid_b_unexpected", 1, 0);
            else begin
                e = qb.pop_front();
                check("rd_latency_b", cyc, e.cyc);
                check("rd_data_b", rd_data_b, e.val);
            end
        end
    end

    task automatic commit();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sreset = 1'b0; clear = 1'b0; snap_req = 1'b0; rd_en = 1'b0;
        tap_tvalid = '0; tap_tlast = '0; tap_tready = '1;
    endtask

    task automatic set_keep(input int t, input int n);
        logic [DB-1:0] k;
        k = (n >= DB) ? '1 : ((64'd1 << n) - 64'd1);
        tap_tkeep[t*DB +: DB] = k;
    endtask

    task automatic beat(input int t, input int n, input bit last, input bit rdy);
        idle();
        tap_tvalid[t] = 1'b1; tap_tready[t] = rdy; tap_tlast[t] = last;
        set_keep(t, n);
        commit();
    endtask

    task automatic snap();
        idle(); snap_req = 1'b1; commit();
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            idle(); rd_en = 1'b1; rd_addr = AW'(a); commit();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sreset = 1'b1;
        repeat (3) commit();
        check("reset_rd_valid_a", rd_valid_a, 0);
        check("reset_rd_valid_b", rd_valid_b, 0);
        check("reset_rd_data_a", rd_data_a, 0);
        check("reset_rd_data_b", rd_data_b, 0);
        check("reset_snap_done_a", snap_done_a, 0);
        check("reset_snap_done_b", snap_done_b, 0);
        idle(); snap(); read_all();

        // Tap 0: three 138-byte packets; tap 1: stalled beats around a 2-beat packet.
        for (int p = 0; p < 3; p++) begin
            beat(0, 64, 0, 1); beat(0, 64, 0, 1); beat(0, 10, 1, 1);
        end
        beat(1, 64, 0, 0); beat(1, 64, 0, 1); beat(1, 64, 0, 0); beat(1, 64, 0, 0);
        beat(1, 64, 1, 1);
        // Tap 2: 2048-byte oversize packet then a 128-byte packet.
        for (int i = 0; i < 31; i++) beat(2, 64, 0, 1);
        beat(2, 64, 1, 1); beat(2, 64, 0, 1); beat(2, 64, 1, 1);
        snap(); read_all();

        // Snapshot coincident with a tlast beat, then clear coincident with tlast.
        for (int i = 0; i < 5; i++) beat(0, 20, 1, 1);
        idle(); tap_tvalid[0] = 1'b1; tap_tlast[0] = 1'b1; set_keep(0, 20); snap_req = 1'b1;
        commit();
        read_all();
        idle(); tap_tvalid[0] = 1'b1; tap_tlast[0] = 1'b1; set_keep(0, 40); clear = 1'b1;
        commit();
        snap(); read_all();
        // Snapshot with clear in the same cycle, and a read in the snap_req cycle.
        beat(1, 33, 1, 1);
        idle(); tap_tvalid[1] = 1'b1; tap_tlast[1] = 1'b1; set_keep(1, 7);
        snap_req = 1'b1; clear = 1'b1; rd_en = 1'b1; rd_addr = AW'(5);
        commit();
        read_all();

        // Reset mid-packet, then a trailing tlast beat counts as a fresh packet.
        beat(0, 64, 0, 1); beat(0, 64, 0, 1);
        idle(); sreset = 1'b1; commit();
        beat(0, 30, 1, 1);
        snap(); read_all();

        // Length accumulator saturation on a very long packet.
        for (int i = 0; i < 1100; i++) beat(2, 64, 0, 1);
        beat(2, 64, 1, 1);
        snap(); read_all();

        // Bulk single-beat packets on all taps: drives 16-bit counters past all-ones.
        for (int i = 0; i < 65540; i++) begin
            idle(); tap_tvalid = '1; tap_tlast = '1;
            for (int t = 0; t < NT; t++) set_keep(t, int'($urandom_range(0, DB)));
            commit();
        end
        snap(); read_all();

        for (int i = 0; i < 4000; i++) begin
            idle();
            for (int t = 0; t < NT; t++) begin
                tap_tvalid[t] = ($urandom_range(0, 3) != 0);
                tap_tready[t] = ($urandom_range(0, 4) != 0);
                tap_tlast[t]  = ($urandom_range(0, 24) == 0);
                set_keep(t, ($urandom_range(0, 9) < 7) ? DB : int'($urandom_range(0, DB)));
            end
            snap_req = ($urandom_range(0, 24) == 0);
            clear    = ($urandom_range(0, 99) == 0);
            rd_en    = ($urandom_range(0, 2) == 0);
            rd_addr  = AW'($urandom_range(0, 15));
            sreset   = ($urandom_range(0, 499) == 0);
            commit();
        end
        snap(); read_all();

        idle();
        repeat (4) commit();
        check("rd_queue_a_drained", qa.size(), 0);
        check("rd_queue_b_drained", qb.size(), 0);
        check("snap_queue_drained", snap_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/p4_router_tap_stats.md
Name: p4_router_tap_stats

Overview:
- Parametrised statistics block that replaces fixed 64-bit debug packet counters in the router queue path.
- Snoops NUM_TAPS AXIS handshakes, for example the policer input, enqueue and dequeue points, without driving them.
- Per tap it keeps a packet count, a byte count, an oversize-packet count and the maximum packet length seen.
- Supports an atomic snapshot of all counters, optional clear-on-snapshot, and a synchronous register-style readout.

Parameters:
- NUM_TAPS, 3, number of monitored AXIS streams (1..16).
- DATA_BYTES, 64, tkeep width per tap.
- CNT_WIDTH, 64, width of every counter and of rd_data (16..64).
- MTU_BYTES, 2000, packet length above which the oversize counter increments.
- SATURATE, 1, 1: counters stick at all-ones; 0: counters wrap to 0.
- CLEAR_ON_SNAP, 0, 1: live counters are cleared when a snapshot is taken.

Ports:
- clk, in, 1, sole clock.
- sreset, in, 1, synchronous active-high reset.
- tap_tvalid, in, NUM_TAPS, snooped tvalid per tap.
- tap_tready, in, NUM_TAPS, snooped tready per tap; tie to 1 for streams without backpressure.
- tap_tlast, in, NUM_TAPS, snooped tlast per tap.
- tap_tkeep, in, NUM_TAPS*DATA_BYTES, snooped tkeep; tap i occupies bits [i*DATA_BYTES +: DATA_BYTES].
- clear, in, 1, one-cycle pulse that zeroes all live counters and length state.
- snap_req, in, 1, one-cycle pulse that copies all live counters into shadow registers.
- snap_done, out, 1, one-cycle pulse when the shadow registers are updated.
- rd_en, in, 1, read strobe.
- rd_addr, in, $clog2(NUM_TAPS)+2, address {tap, sel}; sel 0 = packets, 1 = bytes, 2 = oversize, 3 = max length.
- rd_data, out, CNT_WIDTH, shadow value for the addressed counter.
- rd_valid, out, 1, rd_data qualifier.

Behaviour:
- Reset: all live counters, shadows, per-tap length accumulators, max registers, snap_done, rd_valid and rd_data go to 0.
- A beat on tap i counts only when tap_tvalid[i] and tap_tready[i] are both 1. A tvalid without tready is ignored.
- Beat bytes = popcount(tkeep slice), computed at width $clog2(DATA_BYTES+1).
- tkeep must be contiguous. Gaps are not checked; popcount is taken as-is.
- Per-tap packet length accumulator:
  - Is 16 bits wide and saturates at 65535.
  - Adds the beat bytes on every counted beat.
  - On a tlast beat, the final length is the accumulator plus the beat bytes. The accumulator then returns to 0 on the next cycle.
- On a tlast beat, in the same cycle the final length becomes known:
  - packets += 1.
  - If the final length is greater than MTU_BYTES, oversize += 1.
  - If the final length is greater than max, max is set to the final length, zero-extended to CNT_WIDTH.
- Byte counter: on every counted beat, bytes += beat bytes. Bytes are counted per beat, not per packet.
- All counters update one cycle after the qualifying beat, so registered results are visible at cycle N+1.
- Overflow:
  - SATURATE=1: a counter at all-ones holds.
  - SATURATE=0: the counter wraps modulo 2^CNT_WIDTH.
  - For the byte counter in saturate mode, the sum is clamped to all-ones.
- Snapshot:
  - A snap_req at cycle N copies every live counter as it stands at the start of N into the shadows.
  - snap_done pulses at N+1.
  - Increments occurring in cycle N are not in the snapshot.
  - With CLEAR_ON_SNAP=1, each live counter becomes 0 plus cycle N's increment, so no event is lost.
- clear vs other events:
  - clear has priority over an increment in the same cycle: the result is 0 and the increment is dropped.
  - If clear and snap_req coincide, the snapshot captures the pre-clear values.
  - clear also zeroes the in-flight length accumulators, so a packet in progress restarts its length at its next beat.
- Readout:
  - rd_en at cycle N gives rd_valid=1 and rd_data = shadow[rd_addr] at N+1. rd_valid is 0 otherwise.
  - A tap index >= NUM_TAPS returns rd_data=0 with rd_valid=1.
  - A read coinciding with snap_done returns the newly latched shadow value.
- sreset mid-packet discards the partial length; that packet's remaining beats are counted as a new packet.
- No backpressure is ever asserted; the block is purely observational.

Test Plan:
- Tap 0, three packets of 64+64+10 bytes each (last beat tkeep = 0x3FF), tready=1, then snap_req and reads → packets=3, bytes=414, oversize=0, max=138.
- Tap 1, beats with tvalid=1 and tready=0 interleaved with accepted beats of one 2-beat packet → packets=1, bytes=128; stalled beats not counted.
- Tap 2, one packet of 32 full beats (2048 B) with MTU_BYTES=2000 → oversize=1, max=2048; then a 128 B packet → max stays 2048.
- CNT_WIDTH=16, SATURATE=1, packet counter preloaded to 0xFFFE by stimulus, then three packets → reads 0xFFFF; with SATURATE=0 → reads 0x0001.
- CLEAR_ON_SNAP=1, tlast beat coincident with snap_req while the live count is 5 → shadow=5, live=1, snap_done one cycle later; then clear coincident with a tlast beat → live=0.
- rd_addr with tap=3 when NUM_TAPS=3 → rd_valid=1, rd_data=0; sreset asserted mid-packet then 1 trailing beat with tlast → all counters restart, packets=1.
